// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide (shift-add / restoring), SAIL_MULDIV_FASTPATH_EN skips CALC for trivial ops
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] f3_q, f3_d;
  logic neg_q, neg_d, dz_q, dz_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] a_q, a_d, op_q, op_d, result_q, result_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mul_nx, div_nx, prod;
  logic [WIDTH:0] sum, diff;
  logic [WIDTH-1:0] a_mag, b_mag, quo, rem, calc_res;
  logic a_sgn, b_sgn, b_in_sign, sgn_in, dz_in, ovf_in;
  assign a_sgn     = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3[2] & ~funct3[0]);
  assign b_sgn     = (funct3 == 3'b001) | (funct3[2] & ~funct3[0]);
  assign b_in_sign = (funct3 == 3'b001) | (funct3 == 3'b100);
  assign a_mag     = (a_sgn & A[WIDTH-1]) ? -A : A;
  assign b_mag     = (b_sgn & B[WIDTH-1]) ? -B : B;
  assign sgn_in    = (a_sgn & A[WIDTH-1]) ^ (b_in_sign & B[WIDTH-1]);
  assign dz_in     = funct3[2] & (B == '0);
  assign ovf_in    = funct3[2] & ~funct3[0] & (A == {1'b1, {(WIDTH-1){1'b0}}}) & (B == '1);
  // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
  assign sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? op_q : {WIDTH{1'b0}}};
  assign diff   = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, op_q};
  assign mul_nx = {sum, acc_q[WIDTH-1:1]};
  assign div_nx = {diff[WIDTH] ? acc_q[2*WIDTH-2:WIDTH-1] : diff[WIDTH-1:0], acc_q[WIDTH-2:0], ~diff[WIDTH]};
  assign prod   = neg_q ? -mul_nx : mul_nx;
  assign quo    = neg_q ? -div_nx[WIDTH-1:0] : div_nx[WIDTH-1:0];
  assign rem    = neg_q ? -div_nx[2*WIDTH-1:WIDTH] : div_nx[2*WIDTH-1:WIDTH];
  assign calc_res = ~f3_q[2] ? ((f3_q[1:0] == 2'b00) ? mul_nx[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]) :
                    dz_q     ? (f3_q[1] ? a_q : {WIDTH{1'b1}}) :
                    ovf_q    ? (f3_q[1] ? {WIDTH{1'b0}} : a_q) :
                    f3_q[1]  ? rem : quo;
`ifdef SAIL_MULDIV_FASTPATH_EN
  logic fast_go;
  logic [WIDTH-1:0] fast_res;
  assign fast_go  = dz_in | ovf_in | (~funct3[2] & ((A == '0) | (B == '0)));
  assign fast_res = dz_in  ? (funct3[1] ? A : {WIDTH{1'b1}}) :
                    ovf_in ? (funct3[1] ? {WIDTH{1'b0}} : A) : {WIDTH{1'b0}};
`endif
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    a_d      = a_q;
    op_d     = op_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (state_q == IDLE && op_valid) begin
      state_d = CALC;
      cnt_d   = CW'(WIDTH - 1);
      f3_d    = funct3;
      neg_d   = sgn_in;
      dz_d    = dz_in;
      ovf_d   = ovf_in;
      a_d     = A;
      op_d    = funct3[2] ? b_mag : a_mag;
      acc_d   = funct3[2] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
`ifdef SAIL_MULDIV_FASTPATH_EN
      if (fast_go) begin
        state_d  = DONE;
        result_d = fast_res;
      end
`endif
    end else if (state_q == CALC) begin
      acc_d = f3_q[2] ? div_nx : mul_nx;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        state_d  = DONE;
        result_d = calc_res;
      end
    end else if (state_q == DONE && result_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      a_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      a_q      <= a_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end
  assign op_ready     = state_q == IDLE;
  assign result_valid = state_q == DONE;
  assign busy         = state_q != IDLE;
  assign result       = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed RV32M vectors with hand-computed results and latencies
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic reset, op_valid, op_ready, result_valid, result_ready, busy;
  logic [2:0] funct3;
  logic [31:0] A, B, result;
  int total = 0;
  int bad = 0;
`ifdef SAIL_MULDIV_FASTPATH_EN
  localparam int FL = 1;
`else
  localparam int FL = 33;
`endif
  always #5 clk = ~clk;
  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .funct3(funct3), .A(A), .B(B), .result_valid(result_valid),
    .result_ready(result_ready), .result(result), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit hold);
    int k;
    @(negedge clk);
    op_valid = 1'b1;
    funct3 = f;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    A = '0;
    B = '0;
    check({tag, "_ready_low"}, 32'(op_ready), 32'd0);
    k = 0;
    while (!result_valid && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_lat"}, 32'(k + 1), 32'(lat));
    check(tag, result, exp);
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        op_valid = (i == 5);
        funct3 = 3'b000;
        A = 32'd9;
        B = 32'd9;
        @(posedge clk);
        #1;
        check({tag, "_hold_res"}, result, exp);
        check({tag, "_hold_ready"}, 32'(op_ready), 32'd0);
      end
      op_valid = 1'b0;
      check({tag, "_hold_valid"}, 32'(result_valid), 32'd1);
    end
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check({tag, "_back_idle"}, 32'(op_ready), 32'd1);
    check({tag, "_not_busy"}, 32'(busy), 32'd0);
  endtask
  initial begin
    reset = 1'b1;
    op_valid = 1'b0;
    result_ready = 1'b0;
    funct3 = '0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_op_ready", 32'(op_ready), 32'd1);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);
    do_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0);
    do_op("mulh_neg", 3'b001, 32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFFF, 33, 1'b0);
    do_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
    do_op("mul_zero", 3'b000, 32'd0, 32'd123, 32'd0, FL, 1'b0);
    do_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
    do_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
    do_op("div_nn", 3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 33, 1'b0);
    do_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    do_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33, 1'b0);
    do_op("div_z", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, FL, 1'b0);
    do_op("rem_z", 3'b110, 32'd5, 32'd0, 32'd5, FL, 1'b0);
    do_op("divu_z", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, FL, 1'b0);
    do_op("remu_z", 3'b111, 32'd5, 32'd0, 32'd5, FL, 1'b0);
    do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FL, 1'b0);
    do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, FL, 1'b0);
    do_op("bp", 3'b101, 32'd1000, 32'd10, 32'd100, 33, 1'b1);
    @(negedge clk);
    op_valid = 1'b1;
    funct3 = 3'b100;
    A = 32'd1000;
    B = 32'd3;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    check("mid_busy", 32'(busy), 32'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_ready", 32'(op_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_valid", 32'(result_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        if (result_valid) seen++;
      end
      check("mid_rst_no_pulse", 32'(seen), 32'd0);
    end
    do_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 33, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
